serial_data_selector: RTL and testbench

Parametrised serial-controlled wide multiplexer, successor to the fixed 256×32 data selector. It selects one of CHANNELS words of DATA_WIDTH bits, captures the word on a latch strobe and shifts it out MSB first on a serial read clock. Selection, latch and read strobes are slow external signals, all synchronised to refClock. New in this generation:
- any channel count and width;
- out-of-range detection;
- bit counter and data-valid flag;
- optional auto-increment channel scan;
- asynchronous reset.

---
 rtl/serial_data_selector.sv | 128 ++++++++++++
 tb/tb_serial_data_selector.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_data_selector.sv
// Serial-controlled wide multiplexer: a shifted-in selection picks one of CHANNELS words, which is
// captured on a latch strobe and shifted out MSB first on a serial read strobe.
module serial_data_selector #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CHANNELS   = 256,
  parameter int unsigned SEL_WIDTH  = $clog2(CHANNELS),
  parameter bit          AUTO_INC   = 1'b0
) (
  input  logic                           refClock,
  input  logic                           reset,
  input  logic                           clkSelectorData,
  input  logic                           inSelectorData,
  input  logic                           latchInputData,
  input  logic                           clkReadData,
  input  logic [CHANNELS*DATA_WIDTH-1:0] inData,
  output logic                           outReadData,
  output logic                           dataValid,
  output logic                           selError,
  output logic [SEL_WIDTH-1:0]           selActive
);

  localparam int unsigned BitsWidth = $clog2(DATA_WIDTH + 1);

  // Bit 0 is s0, bit 2 is s2; the event is s1 & ~s2.
  logic [2:0] selSyncQ, latchSyncQ, readSyncQ;
  logic       selEvent, latchEvent, readEvent;

  logic [SEL_WIDTH-1:0]  selShiftQ, selShiftD;
  logic [SEL_WIDTH-1:0]  selActiveQ, selActiveD;
  logic [DATA_WIDTH-1:0] capturedQ, capturedD;
  logic [BitsWidth-1:0]  bitsLeftQ, bitsLeftD;
  logic                  outReadQ, outReadD;
  logic                  selErrorQ, selErrorD;
  logic                  dataValidQ;
  logic [DATA_WIDTH-1:0] selWord;
  logic                  selInRange;

  always_ff @(posedge refClock or posedge reset) begin
    if (reset) begin
      selSyncQ   <= '0;
      latchSyncQ <= '0;
      readSyncQ  <= '0;
    end else begin
      selSyncQ   <= {selSyncQ[1:0], clkSelectorData};
      latchSyncQ <= {latchSyncQ[1:0], latchInputData};
      readSyncQ  <= {readSyncQ[1:0], clkReadData};
    end
  end

  assign selEvent   = selSyncQ[1] & ~selSyncQ[2];
  assign latchEvent = latchSyncQ[1] & ~latchSyncQ[2];
  assign readEvent  = readSyncQ[1] & ~readSyncQ[2];

  // Decoded mux avoids indexing past inData for out-of-range selections.
  always_comb begin
    selWord = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (selShiftQ == SEL_WIDTH'(k)) begin
        selWord = inData[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign selInRange = (32'(selShiftQ) < CHANNELS);

  always_comb begin
    selShiftD  = selShiftQ;
    selActiveD = selActiveQ;
    capturedD  = capturedQ;
    bitsLeftD  = bitsLeftQ;
    outReadD   = outReadQ;
    selErrorD  = selErrorQ;

    if (selEvent) begin
      selShiftD = SEL_WIDTH'({selShiftQ, inSelectorData});
    end

    // Latch has priority: a coincident read is dropped and the output bit holds.
    if (latchEvent) begin
      selActiveD = selShiftQ;
      bitsLeftD  = BitsWidth'(DATA_WIDTH);
      if (selInRange) begin
        capturedD = selWord;
        selErrorD = 1'b0;
      end else begin
        capturedD = '0;
        selErrorD = 1'b1;
      end
      if (AUTO_INC && !selEvent) begin
        selShiftD = (32'(selShiftQ) >= CHANNELS - 1) ? '0 : selShiftQ + SEL_WIDTH'(1);
      end
    end else if (readEvent) begin
      if (bitsLeftQ != '0) begin
        outReadD  = capturedQ[DATA_WIDTH-1];
        capturedD = capturedQ << 1;
        bitsLeftD = bitsLeftQ - BitsWidth'(1);
      end else begin
        outReadD = 1'b0;
      end
    end
  end

  always_ff @(posedge refClock or posedge reset) begin
    if (reset) begin
      selShiftQ  <= '0;
      selActiveQ <= '0;
      capturedQ  <= '0;
      bitsLeftQ  <= '0;
      outReadQ   <= 1'b0;
      selErrorQ  <= 1'b0;
      dataValidQ <= 1'b0;
    end else begin
      selShiftQ  <= selShiftD;
      selActiveQ <= selActiveD;
      capturedQ  <= capturedD;
      bitsLeftQ  <= bitsLeftD;
      outReadQ   <= outReadD;
      selErrorQ  <= selErrorD;
      dataValidQ <= (bitsLeftD != '0);
    end
  end

  assign outReadData = outReadQ;
  assign dataValid   = dataValidQ;
  assign selError    = selErrorQ;
  assign selActive   = selActiveQ;

endmodule

// File: tb/tb_serial_data_selector.sv
// Directed bench: dutA (200 channels, no scan) and dutB (256 channels, auto-increment) share
// all strobes and data inputs.
module tb_serial_data_selector;

  logic               refClock = 1'b0;
  logic               reset = 1'b1;
  logic               clkSelectorData = 1'b0;
  logic               inSelectorData = 1'b0;
  logic               latchInputData = 1'b0;
  logic               clkReadData = 1'b0;
  logic [256*32-1:0]  inData;
  logic               outA, dvA, errA, outB, dvB, errB;
  logic [7:0]         actA, actB;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 refClock = ~refClock;

  serial_data_selector #(
    .DATA_WIDTH(32), .CHANNELS(200), .SEL_WIDTH(8), .AUTO_INC(1'b0)
  ) dutA (
    .refClock(refClock), .reset(reset), .clkSelectorData(clkSelectorData),
    .inSelectorData(inSelectorData), .latchInputData(latchInputData),
    .clkReadData(clkReadData), .inData(inData[200*32-1:0]), .outReadData(outA),
    .dataValid(dvA), .selError(errA), .selActive(actA)
  );

  serial_data_selector #(
    .DATA_WIDTH(32), .CHANNELS(256), .SEL_WIDTH(8), .AUTO_INC(1'b1)
  ) dutB (
    .refClock(refClock), .reset(reset), .clkSelectorData(clkSelectorData),
    .inSelectorData(inSelectorData), .latchInputData(latchInputData),
    .clkReadData(clkReadData), .inData(inData), .outReadData(outB),
    .dataValid(dvB), .selError(errB), .selActive(actB)
  );

  function automatic logic [31:0] chanWord(input int k);
    case (k)
      0:       return 32'h8000_0001;
      3:       return 32'h0F0F_F0F0;
      5:       return 32'hA5A5_0F0F;
      254:     return 32'hDEAD_BEEF;
      255:     return 32'h1234_5678;
      default: return 32'h5555_0000 | 32'(k);
    endcase
  endfunction

  task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // mask = {read, latch, selector}
  task automatic pulse(input logic [2:0] mask, input int hi, input int lo);
    @(negedge refClock);
    clkReadData     = mask[2];
    latchInputData  = mask[1];
    clkSelectorData = mask[0];
    repeat (hi) @(negedge refClock);
    clkReadData     = 1'b0;
    latchInputData  = 1'b0;
    clkSelectorData = 1'b0;
    repeat (lo) @(negedge refClock);
  endtask

  task automatic shiftSel(input logic [7:0] v, input int hi, input int lo);
    for (int i = 7; i >= 0; i--) begin
      inSelectorData = v[i];
      pulse(3'b001, hi, lo);
    end
  endtask

  task automatic readBits(input int n);
    for (int i = 0; i < n; i++) pulse(3'b100, 3, 3);
  endtask

  // dv*[1] = dataValid after bit 31, dv*[0] = after bit 32.
  task automatic readWord(output logic [31:0] wA, output logic [31:0] wB,
                          output logic [1:0] dvAo, output logic [1:0] dvBo);
    wA = '0; wB = '0; dvAo = '0; dvBo = '0;
    for (int i = 0; i < 32; i++) begin
      pulse(3'b100, 3, 3);
      wA = {wA[30:0], outA};
      wB = {wB[30:0], outB};
      if (i == 30) begin dvAo[1] = dvA; dvBo[1] = dvB; end
      if (i == 31) begin dvAo[0] = dvA; dvBo[0] = dvB; end
    end
  endtask

  logic [31:0] wA, wB;
  logic [1:0]  dA, dB;

  initial begin
    for (int k = 0; k < 256; k++) inData[k*32 +: 32] = chanWord(k);

    // Reset values
    repeat (2) @(negedge refClock);
    checkValue("resetA", {outA, dvA, errA, actA}, '0);
    checkValue("resetB", {outB, dvB, errB, actB}, '0);
    reset = 1'b0;
    repeat (2) @(negedge refClock);

    // Basic select and readout of channel 5
    shiftSel(8'h05, 3, 3);
    pulse(3'b010, 3, 3);
    checkValue("latchA", {dvA, errA, actA}, {1'b1, 1'b0, 8'd5});
    readWord(wA, wB, dA, dB);
    checkValue("wordA5", wA, 32'hA5A5_0F0F);
    checkValue("dvFallA", dA, 2'b10);
    checkValue("wordB5", wB, 32'hA5A5_0F0F);
    readBits(1);
    checkValue("bit33", outA, 1'b0);

    // Out of range on dutA (210 >= 200), in range on dutB
    shiftSel(8'd210, 3, 3);
    pulse(3'b010, 3, 3);
    checkValue("oorErrA", {errA, actA}, {1'b1, 8'd210});
    checkValue("oorErrB", errB, 1'b0);
    readWord(wA, wB, dA, dB);
    checkValue("oorWordA", wA, 32'h0);
    checkValue("word210B", wB, 32'h5555_00D2);
    shiftSel(8'd3, 3, 3);
    pulse(3'b010, 3, 3);
    checkValue("recoverA", {errA, actA}, {1'b0, 8'd3});
    readWord(wA, wB, dA, dB);
    checkValue("wordA3", wA, 32'h0F0F_F0F0);

    // Asynchronous reset mid-readout (10 bits left)
    pulse(3'b010, 3, 3);
    readBits(22);
    checkValue("preResetDv", dvA, 1'b1);
    #2 reset = 1'b1;
    #1 checkValue("asyncResetA", {outA, dvA, errA, actA}, '0);
    checkValue("asyncResetB", {outB, dvB, errB, actB}, '0);
    @(negedge refClock);
    clkReadData = 1'b1;
    @(negedge refClock);
    reset = 1'b0;
    repeat (6) @(negedge refClock);
    checkValue("postRelease", {outA, dvA, outB, dvB}, '0);
    clkReadData = 1'b0;
    repeat (3) @(negedge refClock);

    // Auto-increment scan on dutB: 254, 255, 0
    shiftSel(8'hFE, 3, 3);
    pulse(3'b010, 3, 3);
    checkValue("scanAct0", actB, 8'd254);
    readWord(wA, wB, dA, dB);
    checkValue("scanWord0", wB, 32'hDEAD_BEEF);
    pulse(3'b010, 3, 3);
    checkValue("scanAct1", actB, 8'd255);
    readWord(wA, wB, dA, dB);
    checkValue("scanWord1", wB, 32'h1234_5678);
    pulse(3'b010, 3, 3);
    checkValue("scanAct2", actB, 8'd0);
    readWord(wA, wB, dA, dB);
    checkValue("scanWord2", wB, 32'h8000_0001);
    checkValue("scanDvB", dB, 2'b10);

    // Latch + read collision on dutA: read discarded, output bit holds
    shiftSel(8'h05, 3, 3);
    pulse(3'b010, 3, 3);
    readBits(3);
    checkValue("preCollOut", outA, 1'b1);
    shiftSel(8'h03, 3, 3);
    pulse(3'b110, 3, 3);
    checkValue("collOutHold", {outA, dvA, actA}, {1'b1, 1'b1, 8'd3});
    readWord(wA, wB, dA, dB);
    checkValue("collWord", wA, 32'h0F0F_F0F0);
    checkValue("collDv", dA, 2'b10);

    // Latch + selector collision: latch uses pre-shift value, shift overrides increment
    shiftSel(8'h10, 3, 3);
    inSelectorData = 1'b1;
    pulse(3'b011, 3, 3);
    checkValue("lsActA", actA, 8'h10);
    checkValue("lsActB", actB, 8'h10);
    readWord(wA, wB, dA, dB);
    checkValue("lsWordB", wB, 32'h5555_0010);
    pulse(3'b010, 3, 3);
    checkValue("lsNextA", actA, 8'h21);
    checkValue("lsNextB", actB, 8'h21);

    // 2-cycle high / 2-cycle low strobes: exactly one event per pulse
    shiftSel(8'h07, 2, 2);
    pulse(3'b010, 2, 2);
    checkValue("shortStrobe", actA, 8'h07);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
